velocity_cell_pingpong: RTL
===========================

VELOCITY_CELL_PINGPONG -- requirements
Module: velocity_cell_pingpong

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, meaning one particle velocity word {vz, vy, vx}, each 32 bits.
REQ-002 SHALL have parameter PARTICLE_NUM, default 220, meaning words per bank, with address 0 holding the particle count.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, meaning address width, with 2^ADDR_WIDTH >= PARTICLE_NUM.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port rd_en, input, 1 bit: read request to the active bank.
REQ-007 SHALL have port rd_addr, input, ADDR_WIDTH bits: read address.
REQ-008 SHALL have port rd_data, output, DATA_WIDTH bits: registered read data.
REQ-009 SHALL have port rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-010 SHALL have port wr_en, input, 1 bit: write request to the shadow bank.
REQ-011 SHALL have port wr_addr, input, ADDR_WIDTH bits: write address.
REQ-012 SHALL have port wr_data, input, DATA_WIDTH bits: write data, the updated velocity.
REQ-013 SHALL have port swap_req, input, 1 bit: single-cycle pulse requesting a bank swap.
REQ-014 SHALL have port swap_pending, output, 1 bit: a swap has been accepted but not yet executed.
REQ-015 SHALL have port swap_done, output, 1 bit: one-cycle pulse after a swap executes.
REQ-016 SHALL have port active_bank, output, 1 bit: the bank currently served to readers.
REQ-017 SHALL have port wr_count, output, ADDR_WIDTH+1 bits: accepted shadow writes since the last swap.

Function
REQ-018 SHALL hold two banks of PARTICLE_NUM x DATA_WIDTH; reads go to bank active_bank and writes go to bank ~active_bank.
REQ-019 Read latency SHALL be exactly 1 cycle: rd_en=1 at edge N gives rd_data and rd_valid=1 after edge N+1.
REQ-020 A read cycle SHALL use the bank selected at the edge rd_en is sampled; a later swap SHALL NOT alter the data already in flight.
REQ-021 rd_data SHALL be forced to zero and rd_valid=0 in any cycle following rd_en=0.
REQ-022 A read with rd_addr >= PARTICLE_NUM SHALL return zero with rd_valid=1.
REQ-023 A write with wr_addr >= PARTICLE_NUM SHALL be ignored and SHALL NOT increment wr_count.
REQ-024 Each in-range write SHALL increment wr_count, saturating at PARTICLE_NUM.
REQ-025 Writes to the shadow bank SHALL never be visible on rd_data before a swap.
REQ-026 The swap FSM SHALL have three states:
- IDLE: swap_req=1 -> PEND.
- PEND: at the first edge where rd_en=0 and wr_en=0 -> toggle active_bank, clear wr_count to 0, go to DONE.
- DONE: drive swap_done=1 for one cycle -> IDLE.
REQ-027 swap_pending SHALL be 1 exactly while in PEND.
REQ-028 swap_req received in PEND or DONE SHALL be ignored, with no queuing and no second swap.
REQ-029 A swap_req coinciding with rd_en or wr_en SHALL be accepted into PEND; the toggle is deferred per REQ-026.
REQ-030 Reads and writes SHALL remain accepted while in PEND; each such access uses the pre-swap bank mapping.
REQ-031 With PARTICLE_NUM=220, wr_count SHALL saturate at 220.

Reset
REQ-032 When rst is asserted, all of the following SHALL hold immediately, independent of clk:
- rd_data=0, rd_valid=0
- active_bank=0
- wr_count=0
- swap_pending=0, swap_done=0
- FSM in IDLE
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 A reset asserted while in PEND SHALL cancel the pending swap with active_bank=0.
REQ-035 An in-flight read SHALL be discarded by reset (rd_valid=0).

Verification
REQ-036 The bench SHALL cover shadow isolation: write bank1 addr 5 = 0x...AAAA, then read addr 5 -> bank0 value; after swap_req with idle ports, swap_done pulses 2 cycles later and a read of addr 5 returns 0x...AAAA.
REQ-037 The bench SHALL cover a deferred swap: pulse swap_req while holding rd_en=1 for 4 cycles -> swap_pending=1 for 4 cycles, active_bank toggles on the first idle edge, and all 4 reads return pre-swap data.
REQ-038 The bench SHALL cover range and force-to-zero: read addr 220 -> rd_data=0 with rd_valid=1; write addr 230 -> wr_count unchanged; rd_en=0 -> rd_data=0.
REQ-039 The bench SHALL cover the counter: 225 in-range writes -> wr_count=220; after a swap -> wr_count=0.
REQ-040 The bench SHALL cover reset mid-swap: assert rst during PEND -> swap_pending=0 and active_bank=0 immediately, with no swap_done pulse.

Source files
------------

// File: rtl/velocity_cell_pingpong_if.sv
// +--------------------------------------------------------------------+
// | velocity_cell_pingpong_if: read/write/swap bus of the ping-pong   |
// | velocity cell.                                  Rev 1.0           |
// +--------------------------------------------------------------------+
`default_nettype none

interface velocity_cell_pingpong_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  swap_req;
  logic                  swap_pending;
  logic                  swap_done;
  logic                  active_bank;
  logic [ADDR_WIDTH:0]   wr_count;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
    input  rd_data, rd_valid, swap_pending, swap_done, active_bank, wr_count
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
    output rd_data, rd_valid, swap_pending, swap_done, active_bank, wr_count
  );
endinterface

`default_nettype wire

// File: rtl/velocity_cell_pingpong.sv
// +--------------------------------------------------------------------+
// | velocity_cell_pingpong: double-buffered particle velocity store   |
// | with deferred bank swap.                        Rev 1.0           |
// +--------------------------------------------------------------------+
`default_nettype none

module velocity_cell_pingpong #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  velocity_cell_pingpong_if.slave     bus
);

  localparam logic [ADDR_WIDTH:0] c_PNUM = (ADDR_WIDTH + 1)'(PARTICLE_NUM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic                  active_bank_q;
  logic                  swap_pending_q;
  logic                  swap_done_q;
  logic [ADDR_WIDTH:0]   wr_count_q;
  logic [ADDR_WIDTH:0]   wr_count_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  logic                  rd_in_range_w;
  logic                  wr_in_range_w;
  logic                  wr_fire_w;
  logic [DATA_WIDTH-1:0] bank_rd_w [2];

  assign rd_in_range_w = ({1'b0, bus.rd_addr} < c_PNUM);
  assign wr_in_range_w = ({1'b0, bus.wr_addr} < c_PNUM);
  assign wr_fire_w     = bus.wr_en && wr_in_range_w;

  // Each bank accepts writes only while it is the shadow; contents survive reset.
  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam logic c_BANK_ID = 1'(b);
      logic [DATA_WIDTH-1:0] mem_q [PARTICLE_NUM];

      always_ff @(posedge clk) begin
        if (wr_fire_w && (active_bank_q != c_BANK_ID)) begin
          mem_q[bus.wr_addr] <= bus.wr_data;
        end
      end

      assign bank_rd_w[b] = mem_q[bus.rd_addr];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (bus.rd_en) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= rd_in_range_w ? bank_rd_w[active_bank_q] : '0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_fire_w && (wr_count_q != c_PNUM)) begin
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  // The toggle waits for a cycle with no access so no read or write straddles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      active_bank_q  <= 1'b0;
      wr_count_q     <= '0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      wr_count_q  <= wr_count_d;
      swap_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.swap_req) begin
            state_q        <= ST_PEND;
            swap_pending_q <= 1'b1;
          end
        end
        ST_PEND: begin
          if (!bus.rd_en && !bus.wr_en) begin
            state_q        <= ST_DONE;
            active_bank_q  <= ~active_bank_q;
            wr_count_q     <= '0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q        <= ST_IDLE;
          swap_pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.swap_pending = swap_pending_q;
  assign bus.swap_done    = swap_done_q;
  assign bus.active_bank  = active_bank_q;
  assign bus.wr_count     = wr_count_q;

endmodule

`default_nettype wire
